// File: rtl/bird_uart_tx.sv
// Memory-mapped 8N1 UART transmitter for the bird CPU data bus.
// CPU stores push bytes into a circular FIFO; a baud-timed serialiser drains it onto tx.
module bird_uart_tx #(
    parameter logic [11:0] BASE      = 12'hFF0,
    parameter int unsigned DEPTH     = 8,
    parameter logic [15:0] DIV_RESET = 16'd3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [11:0] address,
    input  logic [15:0] wdata,
    input  logic        memwt,
    output logic        hit,
    output logic [15:0] rd_data,
    output logic        tx,
    output logic        irq
);

    localparam int unsigned AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [4:0]  DEPTH_C = 5'(DEPTH);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [4:0]    r_count;
    logic          r_ovf;
    logic [15:0]   r_div;
    logic [1:0]    r_state;
    logic [7:0]    r_shift;
    logic [2:0]    r_bit;
    logic [15:0]   r_baud;

    logic [1:0]    w_off;
    logic          w_full;
    logic          w_empty;
    logic          w_busy;
    logic          w_push_req;
    logic          w_push;
    logic          w_pop;

    assign hit        = (address[11:2] == BASE[11:2]);
    assign w_off      = address[1:0];
    assign w_full     = (r_count == DEPTH_C);
    assign w_empty    = (r_count == 5'd0);
    assign w_busy     = (r_state != S_IDLE);
    assign w_push_req = memwt && hit && (w_off == 2'd0);
    // Fullness is judged on the pre-pop count, so a write racing a pop is still dropped.
    assign w_push     = w_push_req && !w_full;
    assign w_pop      = (r_state == S_IDLE) && !w_empty;
    assign irq        = w_empty && (r_state == S_IDLE);

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= wdata[7:0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
            r_div   <= DIV_RESET;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 5'd1;
                2'b01:   r_count <= r_count - 5'd1;
                default: r_count <= r_count;
            endcase
            if (w_push_req && w_full) begin
                r_ovf <= 1'b1;
            end else if (memwt && hit && (w_off == 2'd1) && wdata[3]) begin
                r_ovf <= 1'b0;
            end
            if (memwt && hit && (w_off == 2'd2)) begin
                r_div <= wdata;
            end
        end
    end

    // Baud counter reloads from r_div at every bit start, so DIV writes land on the next bit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_shift <= '0;
            r_bit   <= '0;
            r_baud  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        r_shift <= r_mem[r_rptr];
                        r_baud  <= r_div;
                        r_state <= S_START;
                    end
                end
                S_START: begin
                    if (r_baud == 16'd0) begin
                        r_baud  <= r_div;
                        r_bit   <= 3'd0;
                        r_state <= S_DATA;
                    end else begin
                        r_baud <= r_baud - 16'd1;
                    end
                end
                S_DATA: begin
                    if (r_baud == 16'd0) begin
                        r_baud  <= r_div;
                        r_shift <= {1'b0, r_shift[7:1]};
                        if (r_bit == 3'd7) begin
                            r_state <= S_STOP;
                        end else begin
                            r_bit <= r_bit + 3'd1;
                        end
                    end else begin
                        r_baud <= r_baud - 16'd1;
                    end
                end
                default: begin
                    if (r_baud == 16'd0) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_baud <= r_baud - 16'd1;
                    end
                end
            endcase
        end
    end

    // tx decodes the state directly so an asynchronous reset raises it without waiting for a clock.
    always_comb begin
        tx = 1'b1;
        case (r_state)
            S_START: tx = 1'b0;
            S_DATA:  tx = r_shift[0];
            default: tx = 1'b1;
        endcase
    end

    always_comb begin
        rd_data = '0;
        if (hit) begin
            case (w_off)
                2'd1:    rd_data = {7'b0, r_count, r_ovf, w_busy, w_empty, w_full};
                2'd2:    rd_data = r_div;
                default: rd_data = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_bird_uart_tx.sv
// Directed bench for bird_uart_tx: register map, FIFO overflow, frame timing and async reset.
`timescale 1ns/1ps
module tb_bird_uart_tx;

    logic        clk;
    logic        reset;
    logic [11:0] address;
    logic [15:0] wdata;
    logic        memwt;
    logic        hit;
    logic [15:0] rd_data;
    logic        tx;
    logic        irq;

    int errors = 0;
    int checks = 0;
    int t      = 0;
    int a      = 0;

    bird_uart_tx #(
        .BASE      (12'hFF0),
        .DEPTH     (8),
        .DIV_RESET (16'd3)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .address (address),
        .wdata   (wdata),
        .memwt   (memwt),
        .hit     (hit),
        .rd_data (rd_data),
        .tx      (tx),
        .irq     (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
        t += n;
    endtask

    task automatic wr(input logic [11:0] addr, input logic [15:0] data);
        address = addr;
        wdata   = data;
        memwt   = 1'b1;
        step(1);
        memwt   = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [11:0] addr, input logic [15:0] exp);
        address = addr;
        #1;
        chk(tag, 64'(rd_data), 64'(exp));
    endtask

    // Waits for the start bit, counting idle-high cycles, then records every cycle of the frame.
    task automatic rx_frame(input string tag, input logic [7:0] b, input int d1, input int exp_idle);
        int idle;
        logic [63:0] obs;
        logic [63:0] exp;
        logic [9:0]  fb;
        fb   = {1'b1, b, 1'b0};
        idle = 0;
        obs  = '0;
        exp  = '0;
        step(1);
        while (tx !== 1'b0 && idle < 200) begin
            idle++;
            step(1);
        end
        chk({tag, " idle"}, 64'(idle), 64'(exp_idle));
        for (int j = 0; j < 10 * d1; j++) begin
            if (j > 0) step(1);
            obs[j] = tx;
            exp[j] = fb[j / d1];
        end
        chk({tag, " frame"}, obs, exp);
    endtask

    initial begin
        reset   = 1'b1;
        address = '0;
        wdata   = '0;
        memwt   = 1'b0;
        step(2);
        chk("reset tx", 64'(tx), 64'(1));
        chk("reset irq", 64'(irq), 64'(1));
        rd("reset status", 12'hFF1, 16'h0002);
        rd("reset div", 12'hFF2, 16'h0003);
        reset = 1'b0;
        step(1);

        // Frame 1: 0x55 at div=3, tx falls one cycle after the write edge
        wr(12'hFF0, 16'h0055);
        chk("post-write tx", 64'(tx), 64'(1));
        rd("post-write status", 12'hFF1, 16'h0010);
        rx_frame("f55", 8'h55, 4, 0);
        rd("last stop status", 12'hFF1, 16'h0006);
        step(1);
        chk("idle irq", 64'(irq), 64'(1));
        rd("idle status", 12'hFF1, 16'h0002);

        // Fill FIFO during an active frame, overflow, clear, drain in order
        a = t;
        wr(12'hFF0, 16'h00EE);
        for (int i = 1; i <= 8; i++) wr(12'hFF0, 16'(i));
        rd("full status", 12'hFF1, 16'h0085);
        wr(12'hFF0, 16'h0009);
        rd("overflow status", 12'hFF1, 16'h008D);
        wr(12'hFF1, 16'h0008);
        rd("ovf cleared status", 12'hFF1, 16'h0085);
        step(a + 41 - t);
        for (int i = 1; i <= 8; i++) rx_frame($sformatf("byte%0d", i), 8'(i), 4, 1);
        step(1);
        chk("drained irq", 64'(irq), 64'(1));

        // div=0: one clock per bit
        wr(12'hFF2, 16'h0000);
        wr(12'hFF0, 16'h00A3);
        rx_frame("fA3", 8'hA3, 1, 0);
        rd("div0 readback", 12'hFF2, 16'h0000);

        // Read sweep, reserved and off-window writes have no effect
        wr(12'hFF2, 16'h0003);
        wr(12'hFF3, 16'hFFFF);
        wr(12'h000, 16'h0077);
        step(1);
        rd("sweep txdata", 12'hFF0, 16'h0000);
        chk("sweep hit ff0", 64'(hit), 64'(1));
        step(1);
        rd("sweep status", 12'hFF1, 16'h0002);
        step(1);
        rd("sweep div", 12'hFF2, 16'h0003);
        step(1);
        rd("sweep reserved", 12'hFF3, 16'h0000);
        chk("sweep hit ff3", 64'(hit), 64'(1));
        step(1);
        rd("sweep outside", 12'h000, 16'h0000);
        chk("sweep hit 000", 64'(hit), 64'(0));
        step(1);
        rd("sweep status again", 12'hFF1, 16'h0002);

        // Async reset during DATA bit 4 at div=5 with one byte still queued
        wr(12'hFF2, 16'h0005);
        a = t;
        wr(12'hFF0, 16'h000F);
        wr(12'hFF0, 16'h0044);
        step(a + 34 - t);
        chk("bit4 tx", 64'(tx), 64'(0));
        reset = 1'b1;
        #1;
        chk("async reset tx", 64'(tx), 64'(1));
        rd("async reset status", 12'hFF1, 16'h0002);
        rd("async reset div", 12'hFF2, 16'h0003);
        step(1);
        reset = 1'b0;
        step(1);
        wr(12'hFF0, 16'h00C6);
        rx_frame("fC6", 8'hC6, 4, 0);

        // Full FIFO: a write on the IDLE->START pop edge is dropped
        a = t;
        wr(12'hFF0, 16'h0011);
        for (int i = 0; i < 8; i++) wr(12'hFF0, 16'(8'h20 + i));
        step(a + 42 - t);
        rd("idle full status", 12'hFF1, 16'h0081);
        wr(12'hFF0, 16'h00FF);
        rd("drop on pop status", 12'hFF1, 16'h007C);
        chk("drop on pop irq", 64'(irq), 64'(0));
        wr(12'hFF1, 16'h0008);
        rd("final clear status", 12'hFF1, 16'h0074);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
